// File: rtl/imem_arbiter_pkg.sv
// Shared widths, FSM encoding and defaults for the instruction-memory arbiter.
package imem_arbiter_pkg;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_CNT_W   = 4;

  localparam logic [0:0] ARB_BOOT = 1'b0;
  localparam logic [0:0] ARB_RUN  = 1'b1;

endpackage

// File: rtl/imem_arb_starve.sv
// Saturating count of consecutive cycles in which fetch asked but lost to the loader.
module imem_arb_starve
  import imem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_f_req,
  input  logic i_f_gnt,
  output logic o_fetch_force
);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (!i_run || i_f_gnt || !i_f_req) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt < STARVE_CNT_W'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign o_fetch_force = (r_starve_cnt >= STARVE_CNT_W'(STARVE_MAX));

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: loader-priority with fetch anti-starvation,
// fetch held off until boot completes, flush kills in-flight fetch responses.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR       = ADDR_W,
  parameter int DATA       = DATA_W,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            boot_done_i,
  input  logic            f_req_i,
  input  logic [ADDR-1:0] f_addr_i,
  input  logic            flush_i,
  output logic            f_gnt_o,
  output logic            f_rvalid_o,
  output logic [DATA-1:0] f_rdata_o,
  input  logic            l_req_i,
  input  logic            l_we_i,
  input  logic [ADDR-1:0] l_addr_i,
  input  logic [DATA-1:0] l_wdata_i,
  output logic            l_gnt_o,
  output logic            l_rvalid_o,
  output logic [DATA-1:0] l_rdata_o,
  output logic            m_en_o,
  output logic            m_we_o,
  output logic [ADDR-1:0] m_addr_o,
  output logic [DATA-1:0] m_wdata_o,
  input  logic [DATA-1:0] m_rdata_i
);

  logic [0:0] r_state;
  logic       r_f_pend;
  logic       r_l_pend;
  logic       w_run;
  logic       w_fetch_force;
  logic       w_f_gnt;
  logic       w_l_gnt;

  assign w_run = (r_state == ARB_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_BOOT;
    end else if (r_state == ARB_BOOT && boot_done_i) begin
      r_state <= ARB_RUN;
    end
  end

  // Grants are gated by rst so nothing reaches the memory while reset is held.
  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (rst) begin
      if (!w_run) begin
        w_l_gnt = l_req_i;
      end else if (f_req_i && l_req_i) begin
        w_f_gnt = w_fetch_force;
        w_l_gnt = !w_fetch_force;
      end else begin
        w_f_gnt = f_req_i;
        w_l_gnt = l_req_i;
      end
    end
  end

  imem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk           (clk),
    .rst           (rst),
    .i_run         (w_run),
    .i_f_req       (f_req_i),
    .i_f_gnt       (w_f_gnt),
    .o_fetch_force (w_fetch_force)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f_pend <= 1'b0;
      r_l_pend <= 1'b0;
    end else begin
      r_f_pend <= w_f_gnt && !flush_i;
      r_l_pend <= w_l_gnt && !l_we_i;
    end
  end

  assign f_gnt_o    = w_f_gnt;
  assign l_gnt_o    = w_l_gnt;
  assign f_rvalid_o = r_f_pend && !flush_i;
  assign l_rvalid_o = r_l_pend;
  assign f_rdata_o  = m_rdata_i;
  assign l_rdata_o  = m_rdata_i;

  assign m_en_o    = w_f_gnt || w_l_gnt;
  assign m_we_o    = w_l_gnt && l_we_i;
  assign m_addr_o  = w_f_gnt ? f_addr_i : (w_l_gnt ? l_addr_i : '0);
  assign m_wdata_o = l_wdata_i;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small behavioural single-port memory.
module tb_imem_arbiter;

  logic        clk;
  logic        rst;
  logic        boot_done_i;
  logic        f_req_i;
  logic [31:0] f_addr_i;
  logic        flush_i;
  logic        f_gnt_o;
  logic        f_rvalid_o;
  logic [31:0] f_rdata_o;
  logic        l_req_i;
  logic        l_we_i;
  logic [31:0] l_addr_i;
  logic [31:0] l_wdata_i;
  logic        l_gnt_o;
  logic        l_rvalid_o;
  logic [31:0] l_rdata_o;
  logic        m_en_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i;

  logic [31:0] mem [0:15];

  int n_chk;
  int n_bad;

  imem_arbiter #(
    .ADDR       (32),
    .DATA       (32),
    .STARVE_MAX (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .boot_done_i (boot_done_i),
    .f_req_i     (f_req_i),
    .f_addr_i    (f_addr_i),
    .flush_i     (flush_i),
    .f_gnt_o     (f_gnt_o),
    .f_rvalid_o  (f_rvalid_o),
    .f_rdata_o   (f_rdata_o),
    .l_req_i     (l_req_i),
    .l_we_i      (l_we_i),
    .l_addr_i    (l_addr_i),
    .l_wdata_i   (l_wdata_i),
    .l_gnt_o     (l_gnt_o),
    .l_rvalid_o  (l_rvalid_o),
    .l_rdata_o   (l_rdata_o),
    .m_en_o      (m_en_o),
    .m_we_o      (m_we_o),
    .m_addr_o    (m_addr_o),
    .m_wdata_o   (m_wdata_o),
    .m_rdata_i   (m_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en_o) begin
      if (m_we_o) mem[m_addr_o[5:2]] <= m_wdata_o;
      else        m_rdata_i <= mem[m_addr_o[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change at negedge; checks follow 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    f_req_i = 1'b0; l_req_i = 1'b0; l_we_i = 1'b0; flush_i = 1'b0; boot_done_i = 1'b0;
  endtask

  initial begin
    bit exp_f;
    bit prev_f;
    bit prev_l;
    n_chk = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    m_rdata_i = 32'h0;
    rst = 1'b0;
    idle();
    f_addr_i = 32'h0; l_addr_i = 32'h0; l_wdata_i = 32'h0;

    // reset: grants and memory controls stay low even with requests present
    l_req_i = 1'b1; f_req_i = 1'b1;
    #1;
    check("rst_f_rvalid", 32'(f_rvalid_o), 32'd0);
    check("rst_l_rvalid", 32'(l_rvalid_o), 32'd0);
    check("rst_l_gnt",    32'(l_gnt_o),    32'd0);
    check("rst_f_gnt",    32'(f_gnt_o),    32'd0);
    check("rst_m_en",     32'(m_en_o),     32'd0);
    step(); step();
    rst = 1'b1;
    idle();

    // 1: fetch held off in BOOT
    for (int i = 0; i < 10; i++) begin
      step(); f_req_i = 1'b1; #1;
      check("boot_f_gnt", 32'(f_gnt_o), 32'd0);
    end
    step();
    l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 32'h4; l_wdata_i = 32'hDEADBEEF; #1;
    check("boot_l_gnt",   32'(l_gnt_o),  32'd1);
    check("boot_f_gnt2",  32'(f_gnt_o),  32'd0);
    check("boot_m_we",    32'(m_we_o),   32'd1);
    check("boot_m_addr",  m_addr_o,      32'h4);
    check("boot_m_wdata", m_wdata_o,     32'hDEADBEEF);
    step(); idle(); #1;
    check("boot_wr_no_rvalid", 32'(l_rvalid_o), 32'd0);

    // 2: boot_done, then fetch granted same cycle, data next cycle
    step(); boot_done_i = 1'b1;
    step(); idle(); f_req_i = 1'b1; f_addr_i = 32'h4; #1;
    check("run_f_gnt",  32'(f_gnt_o), 32'd1);
    check("run_m_en",   32'(m_en_o),  32'd1);
    check("run_m_we",   32'(m_we_o),  32'd0);
    check("run_m_addr", m_addr_o,     32'h4);
    step(); idle(); #1;
    check("run_f_rvalid", 32'(f_rvalid_o), 32'd1);
    check("run_f_rdata",  f_rdata_o,       32'hDEADBEEF);

    // 3: contention, expected L,L,L,L,F repeating
    f_addr_i = 32'h8; l_addr_i = 32'hC; l_we_i = 1'b0;
    prev_f = 1'b0; prev_l = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(); f_req_i = 1'b1; l_req_i = 1'b1; #1;
      exp_f = ((i % 5) == 4);
      check($sformatf("cont_f_gnt_%0d", i), 32'(f_gnt_o), 32'(exp_f));
      check($sformatf("cont_l_gnt_%0d", i), 32'(l_gnt_o), 32'(!exp_f));
      check($sformatf("cont_f_rv_%0d", i), 32'(f_rvalid_o), 32'(prev_f));
      check($sformatf("cont_l_rv_%0d", i), 32'(l_rvalid_o), 32'(prev_l));
      prev_f = exp_f; prev_l = !exp_f;
    end
    step(); idle(); #1;
    check("cont_tail_l_rv", 32'(l_rvalid_o), 32'd1);
    check("cont_tail_f_rv", 32'(f_rvalid_o), 32'd0);

    // 4a: flush in the response cycle
    step(); f_req_i = 1'b1; f_addr_i = 32'h4; #1;
    check("fl_a_gnt", 32'(f_gnt_o), 32'd1);
    step(); idle(); flush_i = 1'b1; #1;
    check("fl_a_rvalid", 32'(f_rvalid_o), 32'd0);
    step(); idle(); #1;
    check("fl_a_rvalid_late", 32'(f_rvalid_o), 32'd0);
    // 4b: flush in the grant cycle
    step(); f_req_i = 1'b1; flush_i = 1'b1; #1;
    check("fl_b_gnt", 32'(f_gnt_o), 32'd1);
    step(); idle(); #1;
    check("fl_b_rvalid", 32'(f_rvalid_o), 32'd0);

    // 5: loader read returns data, loader write never raises rvalid
    step(); l_req_i = 1'b1; l_we_i = 1'b0; l_addr_i = 32'h4; #1;
    check("ld_rd_gnt", 32'(l_gnt_o), 32'd1);
    step(); idle(); #1;
    check("ld_rd_rvalid", 32'(l_rvalid_o), 32'd1);
    check("ld_rd_rdata",  l_rdata_o,       32'hDEADBEEF);
    step(); l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 32'h8; l_wdata_i = 32'h12345678; #1;
    check("ld_wr_gnt",   32'(l_gnt_o), 32'd1);
    check("ld_wr_m_we",  32'(m_we_o),  32'd1);
    step(); idle(); #1;
    check("ld_wr_no_rvalid", 32'(l_rvalid_o), 32'd0);
    step(); f_req_i = 1'b1; f_addr_i = 32'h8; #1;
    check("ld_wr_fetch_gnt", 32'(f_gnt_o), 32'd1);
    step(); idle(); #1;
    check("ld_wr_fetch_rdata", f_rdata_o, 32'h12345678);
    check("ld_wr_fetch_rv",    32'(f_rvalid_o), 32'd1);

    // 6: reset between grant and response
    step(); f_req_i = 1'b1; f_addr_i = 32'h4; #1;
    check("mid_rst_gnt", 32'(f_gnt_o), 32'd1);
    step(); rst = 1'b0; #1;
    check("mid_rst_f_rvalid", 32'(f_rvalid_o), 32'd0);
    check("mid_rst_f_gnt",    32'(f_gnt_o),    32'd0);
    check("mid_rst_m_en",     32'(m_en_o),     32'd0);
    step(); rst = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      step(); f_req_i = 1'b1; #1;
      check("post_rst_f_gnt",    32'(f_gnt_o),    32'd0);
      check("post_rst_f_rvalid", 32'(f_rvalid_o), 32'd0);
    end
    step(); f_req_i = 1'b0; boot_done_i = 1'b1;
    step(); idle(); f_req_i = 1'b1; #1;
    check("rerun_f_gnt", 32'(f_gnt_o), 32'd1);
    step(); idle(); #1;
    check("rerun_f_rdata", f_rdata_o, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-port synchronous instruction memory between the fetch stage (read-only) and the program loader / debug port (read/write).
- Holds fetch off after reset until the loader signals boot completion.
- Then arbitrates per cycle: loader has priority, with anti-starvation for fetch.
- Cancels in-flight fetch responses on a branch redirect so the fetch stage never sees a stale instruction.

Parameters:
ADDR, 32, address width in bits (same value as the codebase-wide ADDR).
DATA, 32, memory word width in bits.
STARVE_MAX, 4, consecutive denied fetch cycles after which fetch wins the next contention; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
boot_done_i  in  1  loader finished initial program load; sampled in BOOT only.
f_req_i  in  1  fetch read request.
f_addr_i  in  ADDR  fetch read address.
flush_i  in  1  branch redirect from fetch; cancels any outstanding fetch response.
f_gnt_o  out  1  fetch request accepted this cycle (combinational).
f_rvalid_o  out  1  fetch read data valid.
f_rdata_o  out  DATA  fetch read data (pass-through of m_rdata_i).
l_req_i  in  1  loader request.
l_we_i  in  1  loader write enable (1 = write, 0 = read).
l_addr_i  in  ADDR  loader address.
l_wdata_i  in  DATA  loader write data.
l_gnt_o  out  1  loader request accepted this cycle (combinational).
l_rvalid_o  out  1  loader read data valid.
l_rdata_o  out  DATA  loader read data (pass-through of m_rdata_i).
m_en_o  out  1  memory access enable.
m_we_o  out  1  memory write enable.
m_addr_o  out  ADDR  memory address.
m_wdata_o  out  DATA  memory write data.
m_rdata_i  in  DATA  memory read data, valid the cycle after a read with m_en_o=1.

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT, starve_cnt=0, f_pend=0, l_pend=0. Registered outputs f_rvalid_o=0 and l_rvalid_o=0. Grants and memory controls are 0 during reset.
- FSM states: BOOT, RUN.
  - BOOT -> RUN when boot_done_i=1 at a clock edge.
  - RUN -> RUN forever; only reset returns to BOOT.
- In BOOT:
  - f_gnt_o=0 always.
  - l_gnt_o=l_req_i.
  - starve_cnt is held at 0.
- In RUN, per-cycle arbitration (combinational from current inputs and registered starve_cnt):
  - Only one requester: that requester is granted.
  - Both requesting: fetch is granted if starve_cnt >= STARVE_MAX, otherwise the loader is granted.
  - Exactly one grant at most per cycle.
- starve_cnt (RUN only), evaluated in priority order:
  - Reset to 0 on any cycle where fetch is granted or f_req_i=0.
  - Otherwise increments by 1 when f_req_i=1 and fetch is denied.
  - Saturates at STARVE_MAX.
- Memory drive:
  - m_en_o = f_gnt_o | l_gnt_o.
  - m_we_o = l_gnt_o & l_we_i.
  - m_addr_o and m_wdata_o come from the granted requester.
  - m_wdata_o = l_wdata_i.
  - With no grant, m_addr_o=0.
- Response latency is 1 cycle.
  - Next f_pend = f_gnt_o & ~flush_i.
  - f_rvalid_o = f_pend & ~flush_i. A flush in either the grant cycle or the response cycle kills the response.
  - Next l_pend = l_gnt_o & ~l_we_i.
  - l_rvalid_o = l_pend.
  - Writes produce no rvalid.
- f_rdata_o and l_rdata_o both equal m_rdata_i. Consumers qualify them with their own rvalid.
- A killed fetch still consumes the memory slot. The loader cannot use that slot.
- Back-to-back grants are allowed every cycle. Fetch may receive a grant in the same cycle its previous response returns.
- boot_done_i is ignored in RUN.
- Reset asserted mid-transaction: all pends are cleared immediately and no rvalid is produced afterwards.

Decomposition:
- Shared package / params.vh gains:
  - the ADDR and DATA widths (already present);
  - the FSM state encoding localparams ARB_BOOT=1'b0 and ARB_RUN=1'b1;
  - the STARVE_MAX default.
- One natural sub-module: imem_arb_starve, which holds the saturating starvation counter and produces fetch_force = (starve_cnt >= STARVE_MAX).
- FSM, grant logic and response tracking stay in imem_arbiter.

Test Plan:
1. Reset, then f_req_i=1 with boot_done_i=0 for 10 cycles.
   -> f_gnt_o=0 throughout.
   -> Loader write l_addr_i=0x4, l_wdata_i=0xDEADBEEF gives l_gnt_o=1, m_we_o=1, m_addr_o=0x4.
2. boot_done_i pulse, then f_req_i=1 with f_addr_i=0x4 and l_req_i=0.
   -> f_gnt_o=1 the same cycle.
   -> Next cycle f_rvalid_o=1, f_rdata_o=0xDEADBEEF.
3. RUN with f_req_i=1 and l_req_i=1 held for 12 cycles, STARVE_MAX=4.
   -> Grant pattern L,L,L,L,F repeating.
   -> starve_cnt returns to 0 after each F.
4. Fetch grant at cycle t with flush_i=1 at t+1.
   -> f_rvalid_o=0 at t+1.
   -> Separately, flush_i=1 at t gives f_rvalid_o=0 at t+1 even with flush_i=0 then.
5. Loader read of addr 0x4 granted.
   -> l_rvalid_o=1 next cycle with l_rdata_o=0xDEADBEEF.
   -> A loader write never raises l_rvalid_o.
6. rst driven low between a fetch grant and its response cycle.
   -> f_rvalid_o=0 immediately and f_gnt_o=0.
   -> State returns to BOOT; fetch stays held off until boot_done_i.
